// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        I_EXEC   = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;
    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// R-type func field to ALU operation, with a legality flag for the sequencer.
// Latency: combinational.
// Backpressure: none.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output logic       func_legal
);

    always_comb begin
        alu_op     = ALU_ADD;
        func_legal = 1'b1;
        case (func)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: func_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer stepping each MIPS instruction through fetch..writeback.
// Latency: 2-5 cycles per instruction plus one per memory wait cycle.
// Backpressure: mem_ready low holds FETCH/MEM_RD/MEM_WR with requests stable.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state, state_nxt;
    logic [3:0] r_alu_op;
    logic       func_legal;

    // The branch decision is taken by the datapath from pc_write_cond & zero.
    logic unused_zero;
    assign unused_zero = zero;

    mips_alu_decode u_alu_decode (
        .func       (func),
        .alu_op     (r_alu_op),
        .func_legal (func_legal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_AND;
        instr_done    = 1'b0;
        illegal       = 1'b0;

        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_nxt = DECODE;
            end
            DECODE: begin
                // ALUOut captures the branch target speculatively.
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_nxt = MEM_ADDR;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_ADDI:      state_nxt = I_EXEC;
                    OP_J:         state_nxt = JUMP;
                    OP_RTYPE: begin
                        if (func_legal) begin
                            state_nxt = R_EXEC;
                        end else begin
                            illegal   = 1'b1;
                            state_nxt = FETCH;
                        end
                    end
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_nxt = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_nxt = FETCH;
            end
            R_EXEC: begin
                alu_src_a = SRCA_REG;
                alu_op    = r_alu_op;
                state_nxt = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            I_EXEC: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ADD;
                state_nxt = I_WB;
            end
            I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            BRANCH: begin
                alu_src_a     = SRCA_REG;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
                state_nxt     = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            default: state_nxt = FETCH;
        endcase

        // An instruction caught by reset must leave no architectural trace.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            instr_done    = 1'b0;
            illegal       = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            instr_count <= '0;
        end else if (instr_done) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against a per-instruction cycle model.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       sa;
        logic [1:0] sb;
        logic [3:0] alu;
        logic       done;
        logic       ill;
    } ctl_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       opcode = '0;
    logic [5:0]       func = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
    logic [1:0]       pc_source, alu_src_b;
    logic [3:0]       alu_op;
    logic [CNT_W-1:0] instr_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .opcode        (opcode),
        .func          (func),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .illegal       (illegal),
        .instr_count   (instr_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t fetch_v(input logic rdy);
        ctl_t c = '0;
        c.mrd = 1'b1;
        c.sb  = 2'b01;
        c.alu = 4'b0010;
        c.irw = rdy;
        c.pcw = rdy;
        return c;
    endfunction

    function automatic ctl_t gate_rst(input ctl_t c);
        ctl_t g = c;
        g.pcw = 0; g.pcwc = 0; g.irw = 0; g.mrd = 0;
        g.mwr = 0; g.rw = 0; g.done = 0; g.ill = 0;
        return g;
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2a:   return 4'b0111;
            default: return 4'bxxxx;
        endcase
    endfunction

    function automatic bit fn_ok(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    endfunction

    function automatic bit op_ok(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) return fn_ok(fn);
        return op inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 ns later.
    task automatic step(input string tag, input logic rst, input logic rdy,
                        input logic [5:0] op, input logic [5:0] fn, input ctl_t exp);
        ctl_t obs;
        @(negedge clock);
        reset     = rst;
        mem_ready = rdy;
        opcode    = op;
        func      = fn;
        zero      = 1'($urandom);
        #1;
        obs = '{pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                instr_done, illegal};
        chk({tag, ".ctl"}, 64'(obs), 64'(exp));
        chk({tag, ".cnt"}, 64'(instr_count), 64'(exp_cnt));
    endtask

    // Expected per-cycle controls for one instruction; reset lands on cycle rst_at.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input int rst_at);
        ctl_t cyc[$];
        logic rdy[$];
        ctl_t c;
        bit   ok = op_ok(op, fn);
        for (int i = 0; i < wf; i++) begin cyc.push_back(fetch_v(0)); rdy.push_back(0); end
        cyc.push_back(fetch_v(1)); rdy.push_back(1);
        c = '0; c.sb = 2'b10; c.alu = 4'b0010; c.ill = !ok;
        cyc.push_back(c); rdy.push_back(1'($urandom));
        if (ok) begin
            case (op)
                6'b000010: begin
                    c = '0; c.pcw = 1; c.pcs = 2'b10; c.done = 1;
                    cyc.push_back(c); rdy.push_back(1'($urandom));
                end
                6'b000100: begin
                    c = '0; c.sa = 1; c.alu = 4'b0110; c.pcwc = 1; c.pcs = 2'b01; c.done = 1;
                    cyc.push_back(c); rdy.push_back(1'($urandom));
                end
                6'b000000, 6'b001000: begin
                    c = '0; c.sa = 1;
                    if (op == 6'b000000) c.alu = r_alu(fn);
                    else begin c.sb = 2'b10; c.alu = 4'b0010; end
                    cyc.push_back(c); rdy.push_back(1'($urandom));
                    c = '0; c.rw = 1; c.rdst = (op == 6'b000000); c.done = 1;
                    cyc.push_back(c); rdy.push_back(1'($urandom));
                end
                default: begin
                    c = '0; c.sa = 1; c.sb = 2'b10; c.alu = 4'b0010;
                    cyc.push_back(c); rdy.push_back(1'($urandom));
                    for (int i = 0; i <= wm; i++) begin
                        c = '0; c.iord = 1;
                        if (op == 6'b101011) begin c.mwr = 1; c.done = (i == wm); end
                        else c.mrd = 1;
                        cyc.push_back(c); rdy.push_back(i == wm);
                    end
                    if (op == 6'b100011) begin
                        c = '0; c.rw = 1; c.m2r = 1; c.done = 1;
                        cyc.push_back(c); rdy.push_back(1'($urandom));
                    end
                end
            endcase
        end
        for (int i = 0; i < cyc.size(); i++) begin
            string t = $sformatf("%s.c%0d", tag, i + 1);
            if (i == rst_at) begin
                step(t, 1'b1, rdy[i], op, fn, gate_rst(cyc[i]));
                exp_cnt = 0;
                return;
            end
            step(t, 1'b0, rdy[i], op, fn, cyc[i]);
            if (cyc[i].done) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        int k;
        // Reset holds every enable low regardless of mem_ready.
        for (int i = 0; i < 3; i++) begin
            logic r = 1'($urandom);
            step($sformatf("rst%0d", i), 1'b1, r, 6'h00, 6'h20, gate_rst(fetch_v(r)));
        end

        run_instr("add",     6'b000000, 6'h20, 0, 0, -1);
        run_instr("lw_w2",   6'b100011, 6'h00, 0, 2, -1);
        run_instr("beq_a",   6'b000100, 6'h00, 0, 0, -1);
        run_instr("beq_b",   6'b000100, 6'h00, 1, 0, -1);
        run_instr("ill_op",  6'b111111, 6'h00, 0, 0, -1);
        run_instr("ill_fn",  6'b000000, 6'h00, 0, 0, -1);
        run_instr("sw_w1",   6'b101011, 6'h00, 2, 1, -1);
        run_instr("addi",    6'b001000, 6'h00, 0, 0, -1);
        run_instr("sw_rst",  6'b101011, 6'h00, 0, 0, 3);
        run_instr("post_rst",6'b000000, 6'h2a, 0, 0, -1);

        // Counter wraps after 16 retirements from zero.
        run_instr("rst_w",   6'b000010, 6'h00, 0, 0, 0);
        for (int i = 0; i < 16; i++) run_instr($sformatf("j%0d", i), 6'b000010, 6'h00, 0, 0, -1);
        @(negedge clock); #1;
        chk("wrap", 64'(instr_count), 64'd0);

        for (int n = 0; n < 150; n++) begin
            k  = $urandom_range(0, 7);
            fn = 6'h00;
            case (k)
                0: begin op = 6'b000000;
                         case ($urandom_range(0, 4))
                             0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
                             3: fn = 6'h25; default: fn = 6'h2a;
                         endcase end
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                6: begin op = 6'($urandom); fn = 6'($urandom); end
                default: begin op = 6'b000000;
                         do fn = 6'($urandom); while (fn_ok(fn)); end
            endcase
            run_instr($sformatf("r%0d", n), op, fn, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control sequencer for the MIPS core datapath. It replaces per-instruction single-cycle decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives the enables and mux selects for the PC, instruction register, register file, ALU and the shared instruction/data memory. A ready handshake lets the shared memory stall the sequence.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by zero
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  write register: 0 rt, 1 rd
- mem_to_reg  out  1  write data: 0 ALUOut, 1 MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 register B, 01 constant 1 (word-addressed PC), 10 sign-extended imm
- alu_op  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- instr_done  out  1  one-cycle pulse on final state of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode or func
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Supported opcodes: R-type 000000 (func 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt), lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00. ir_write and pc_write equal mem_ready. Stay while !mem_ready, otherwise go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=10, ADD (branch target to ALUOut). Next state by opcode:
  - lw/sw → MEM_ADDR
  - R → R_EXEC
  - beq → BRANCH
  - addi → I_EXEC
  - j → JUMP
  - Illegal opcode or R-type func → illegal=1, FETCH, no count.
- MEM_ADDR: src_a=1, src_b=10, ADD. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, done. Next FETCH.
- MEM_WR: mem_write=1, iord=1. Wait for mem_ready; done on the ready cycle, then FETCH.
- R_EXEC: src_a=1, src_b=00, alu_op from func. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, done. Next FETCH.
- I_EXEC: src_a=1, src_b=10, ADD. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, done. Next FETCH.
- BRANCH: src_a=1, src_b=00, SUB, pc_write_cond=1, pc_source=01, done. Next FETCH.
- JUMP: pc_write=1, pc_source=10, done. Next FETCH.
- Unlisted outputs are 0 in every state. instr_count increments on every instr_done.

## Timing
- Reset: state ← FETCH and instr_count ← 0. While reset is high, every enable (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write) is forced 0, along with instr_done and illegal.
- Reset mid-instruction abandons it; there is no count and no write in that cycle.
- Outputs are a Moore decode of the registered state. Exceptions, which are combinational, are ir_write/pc_write in FETCH (gated by mem_ready) and instr_done in MEM_WR.
- Cycles with zero wait: beq 3, j 3, R 4, addi 4, sw 4, lw 5, illegal 2. Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- Request signals hold stable until mem_ready.

## Structure
- Shared package mips_ctrl_pkg holds:
  - the state enum (FETCH=0 … JUMP=11, 4-bit)
  - ALU op constants
  - opcode/func constants
  - mux-select constants
- Sub-module mips_alu_decode (combinational: func → alu_op, func_legal), instantiated once.

## Test plan
- R-type add, zero-wait, after reset: states FETCH, DECODE, R_EXEC, R_WB. reg_write=1 and reg_dst=1 only in cycle 4; instr_count=1.
- lw with mem_ready low 2 cycles in MEM_RD: 7 cycles total; mem_read/iord=1 held for 3 cycles; reg_write with mem_to_reg=1 in cycle 7.
- beq with zero=1 and then zero=0: pc_write_cond=1, pc_source=01 in cycle 3 both times, instr_done each time, count +2.
- Opcode 111111, then R-type func 000000: illegal pulses in DECODE, FETCH follows, count unchanged.
- reset asserted during MEM_WR with mem_ready=1: no mem_write and no done; next state FETCH, count 0.
- CNT_W=4, 16 j instructions: instr_count wraps to 0.
